lsu_queued: RTL and testbench

LSU_QUEUED -- requirements
Module: lsu_queued

---
 rtl/lsu_queued_pkg.sv | 40 ++++
 rtl/lsu_req_fifo.sv | 57 +++++
 rtl/lsu_queued.sv | 136 +++++++++++++
 tb/tb_lsu_queued.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_queued_pkg.sv
// Shared core types for the queued load/store unit: decoded uop, access-size
// encodings and the queued request record.
package lsu_queued_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned STRB_W = XLEN / 8;

  localparam logic [1:0] LSU_B = 2'b00;
  localparam logic [1:0] LSU_H = 2'b01;
  localparam logic [1:0] LSU_W = 2'b10;

  typedef struct packed {
    logic            is_load;
    logic            is_store;
    logic [XLEN-1:0] imm;
    logic [1:0]      lsu_access_size;
    logic            lsu_sign_extend;
  } uop_t;

  typedef struct packed {
    uop_t            uop;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] store_data;
    logic            misaligned;
  } lsu_req_t;

  // Size 2'b11 is reserved and always faults.
  function automatic logic is_misaligned(logic [1:0] size, logic [1:0] lsb);
    logic mis;
    mis = 1'b1;
    case (size)
      LSU_B:   mis = 1'b0;
      LSU_H:   mis = lsb[0];
      LSU_W:   mis = (lsb != 2'b00);
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_req_fifo.sv
// In-order request queue for the LSU; flush empties it on the next edge.
module lsu_req_fifo
  import lsu_queued_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  lsu_req_t               wr_data,
  output lsu_req_t               rd_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  lsu_req_t         mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (count < CNT_W'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign rd_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      mem    <= '{default: '0};
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/lsu_queued.sv
// Queued load/store unit: buffers issued uops, presents the head to memory,
// and retires results in order through registered outputs.
module lsu_queued
  import lsu_queued_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  uop_t              i_uop,
  input  logic [XLEN-1:0]   i_addr_base,
  input  logic [XLEN-1:0]   i_store_data,
  input  logic              i_flush,
  output logic              dmem_m_valid,
  output logic [XLEN-1:0]   dmem_m_addr,
  output logic [XLEN-1:0]   dmem_m_wdata,
  output logic [STRB_W-1:0] dmem_m_wstrb,
  input  logic              dmem_s_ready,
  input  logic [XLEN-1:0]   dmem_s_rdata,
  output logic              o_valid,
  output logic [XLEN-1:0]   o_load_data,
  output uop_t              o_lsu_uop,
  output logic              o_misaligned,
  output logic [XLEN-1:0]   o_fault_addr,
  output logic              o_busy
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [CNT_W-1:0] count;
  lsu_req_t         enq_req;
  lsu_req_t         head;
  logic             enq;
  logic             head_valid;
  logic             retire;
  logic             retire_vis;
  logic [XLEN-1:0]  load_ext;

  assign o_ready    = (count < CNT_W'(DEPTH));
  assign o_busy     = (count != '0);
  assign head_valid = o_busy;
  assign enq        = i_valid && o_ready && !i_flush;
  assign retire     = head_valid && (head.misaligned || dmem_s_ready);
  assign retire_vis = retire && !i_flush;

  // Effective address and alignment are resolved once, at enqueue.
  always_comb begin
    enq_req            = '0;
    enq_req.uop        = i_uop;
    enq_req.addr       = i_addr_base + i_uop.imm;
    enq_req.store_data = i_store_data;
    enq_req.misaligned = is_misaligned(i_uop.lsu_access_size, enq_req.addr[1:0]);
  end

  lsu_req_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (enq),
    .pop     (retire),
    .flush   (i_flush),
    .wr_data (enq_req),
    .rd_data (head),
    .count   (count)
  );

  // Memory request straight from the registered head entry, so it holds until accepted.
  always_comb begin
    dmem_m_valid = head_valid && !head.misaligned;
    dmem_m_addr  = head.addr;
    dmem_m_wdata = '0;
    dmem_m_wstrb = '0;
    if (head.uop.is_store) begin
      case (head.uop.lsu_access_size)
        LSU_B: begin
          dmem_m_wdata = {4{head.store_data[7:0]}};
          dmem_m_wstrb = 4'b0001 << head.addr[1:0];
        end
        LSU_H: begin
          dmem_m_wdata = {2{head.store_data[15:0]}};
          dmem_m_wstrb = 4'b0011 << head.addr[1:0];
        end
        default: begin
          dmem_m_wdata = head.store_data;
          dmem_m_wstrb = 4'b1111;
        end
      endcase
    end
  end

  function automatic logic [XLEN-1:0] extend_load(logic [XLEN-1:0] rdata, logic [1:0] lsb,
                                                  logic [1:0] size, logic sext);
    logic [XLEN-1:0] lane;
    logic [XLEN-1:0] res;
    lane = rdata >> {lsb, 3'b000};
    case (size)
      LSU_B:   res = sext ? {{24{lane[7]}}, lane[7:0]} : {24'b0, lane[7:0]};
      LSU_H:   res = sext ? {{16{lane[15]}}, lane[15:0]} : {16'b0, lane[15:0]};
      default: res = lane;
    endcase
    return res;
  endfunction

  assign load_ext = extend_load(dmem_s_rdata, head.addr[1:0],
                                head.uop.lsu_access_size, head.uop.lsu_sign_extend);

  // Retirement register; a handshake coinciding with flush is not reported.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid      <= 1'b0;
      o_load_data  <= '0;
      o_lsu_uop    <= '0;
      o_misaligned <= 1'b0;
      o_fault_addr <= '0;
    end else begin
      o_valid <= retire_vis;
      if (retire_vis) begin
        o_lsu_uop    <= head.uop;
        o_misaligned <= head.misaligned;
        o_fault_addr <= head.misaligned ? head.addr : '0;
        o_load_data  <= (head.uop.is_load && !head.misaligned) ? load_ext : '0;
      end
    end
  end

  property p_req_stable;
    @(posedge clk) disable iff (!rst_n)
      (dmem_m_valid && !dmem_s_ready && !i_flush) |=>
        (dmem_m_valid && $stable(dmem_m_addr) && $stable(dmem_m_wdata) && $stable(dmem_m_wstrb));
  endproperty
  a_req_stable: assert property (p_req_stable);

endmodule

// File: tb/tb_lsu_queued.sv
// Bench for lsu_queued: table of single-op vectors plus queueing, flush and reset sequences.
module tb_lsu_queued;
  import lsu_queued_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        i_valid;
  logic        o_ready;
  uop_t        i_uop;
  logic [31:0] i_addr_base;
  logic [31:0] i_store_data;
  logic        i_flush;
  logic        dmem_m_valid;
  logic [31:0] dmem_m_addr;
  logic [31:0] dmem_m_wdata;
  logic [3:0]  dmem_m_wstrb;
  logic        dmem_s_ready;
  logic [31:0] dmem_s_rdata;
  logic        o_valid;
  logic [31:0] o_load_data;
  uop_t        o_lsu_uop;
  logic        o_misaligned;
  logic [31:0] o_fault_addr;
  logic        o_busy;

  logic        rdata_mode;
  logic [31:0] rdata_drv;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] load;
    logic        mis;
    logic [31:0] fault;
    uop_t        uop;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } memop_t;

  typedef struct {
    string       name;
    logic        is_load;
    logic        is_store;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] base;
    logic [31:0] imm;
    logic [31:0] sdata;
    logic [31:0] rdata;
    logic [31:0] exp_addr;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata;
    logic [31:0] exp_load;
    logic        exp_mis;
  } vec_t;

  exp_t   sb[$];
  memop_t memlog[$];
  vec_t   vecs[11];

  lsu_queued #(.DEPTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_uop        (i_uop),
    .i_addr_base  (i_addr_base),
    .i_store_data (i_store_data),
    .i_flush      (i_flush),
    .dmem_m_valid (dmem_m_valid),
    .dmem_m_addr  (dmem_m_addr),
    .dmem_m_wdata (dmem_m_wdata),
    .dmem_m_wstrb (dmem_m_wstrb),
    .dmem_s_ready (dmem_s_ready),
    .dmem_s_rdata (dmem_s_rdata),
    .o_valid      (o_valid),
    .o_load_data  (o_load_data),
    .o_lsu_uop    (o_lsu_uop),
    .o_misaligned (o_misaligned),
    .o_fault_addr (o_fault_addr),
    .o_busy       (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_fn(logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  assign dmem_s_rdata = rdata_mode ? mem_fn(dmem_m_addr) : rdata_drv;

  function automatic uop_t mk_uop(logic l, logic s, logic [1:0] size, logic sext, logic [31:0] imm);
    uop_t u;
    u.is_load         = l;
    u.is_store        = s;
    u.imm             = imm;
    u.lsu_access_size = size;
    u.lsu_sign_extend = sext;
    return u;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: log memory handshakes and score each retirement.
  always @(negedge clk) begin
    if (dmem_m_valid && dmem_s_ready)
      memlog.push_back('{addr: dmem_m_addr, wdata: dmem_m_wdata, wstrb: dmem_m_wstrb});
    if (o_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_retire", 64'(o_valid), 64'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("ret_load_data", 64'(o_load_data), 64'(e.load));
        check("ret_misaligned", 64'(o_misaligned), 64'(e.mis));
        check("ret_fault_addr", 64'(o_fault_addr), 64'(e.fault));
        check("ret_uop", 64'(o_lsu_uop), 64'(e.uop));
      end
    end
  end

  // Offer one uop until accepted; optionally push its expected retirement.
  task automatic issue(input uop_t u, input logic [31:0] base, input logic [31:0] sdata,
                       input bit push_exp, input exp_t e);
    bit acc;
    acc          = 1'b0;
    i_valid      = 1'b1;
    i_uop        = u;
    i_addr_base  = base;
    i_store_data = sdata;
    for (int c = 0; c < 50 && !acc; c++) begin
      acc = o_ready && !i_flush;
      tick();
    end
    i_valid = 1'b0;
    if (!acc) check("issue_timeout", 64'(acc), 64'(1));
    else if (push_exp) sb.push_back(e);
  endtask

  initial begin
    exp_t        e;
    uop_t        u;
    logic [31:0] a;

    rst_n = 1'b0; i_valid = 1'b0; i_uop = '0; i_addr_base = '0; i_store_data = '0;
    i_flush = 1'b0; dmem_s_ready = 1'b0; rdata_mode = 1'b0; rdata_drv = '0;

    vecs[0]  = '{"sb_lane3",  0,1,LSU_B,0, 32'h1000, 32'h3, 32'h000000A5, 32'h0,
                 32'h1003, 4'b1000, 32'hA5A5A5A5, 32'h0, 0};
    vecs[1]  = '{"lh_sext",   1,0,LSU_H,1, 32'h2000, 32'h2, 32'h0, 32'h80010000,
                 32'h2002, 4'b0000, 32'h0, 32'hFFFF8001, 0};
    vecs[2]  = '{"lw_mis",    1,0,LSU_W,0, 32'h3000, 32'h1, 32'h0, 32'h0,
                 32'h3001, 4'b0000, 32'h0, 32'h0, 1};
    vecs[3]  = '{"lbu_lane1", 1,0,LSU_B,0, 32'h10, 32'h1, 32'h0, 32'h12345678,
                 32'h11, 4'b0000, 32'h0, 32'h56, 0};
    vecs[4]  = '{"lb_sext",   1,0,LSU_B,1, 32'h10, 32'h3, 32'h0, 32'h80FF0000,
                 32'h13, 4'b0000, 32'h0, 32'hFFFFFF80, 0};
    vecs[5]  = '{"sh_upper",  0,1,LSU_H,0, 32'h20, 32'h2, 32'h1234BEEF, 32'h0,
                 32'h22, 4'b1100, 32'hBEEFBEEF, 32'h0, 0};
    vecs[6]  = '{"sw",        0,1,LSU_W,0, 32'h40, 32'h0, 32'hDEADBEEF, 32'h0,
                 32'h40, 4'b1111, 32'hDEADBEEF, 32'h0, 0};
    vecs[7]  = '{"lhu_lane0", 1,0,LSU_H,0, 32'h50, 32'h0, 32'h0, 32'h8001F00D,
                 32'h50, 4'b0000, 32'h0, 32'h0000F00D, 0};
    vecs[8]  = '{"sh_mis",    0,1,LSU_H,0, 32'h60, 32'h1, 32'h5555, 32'h0,
                 32'h61, 4'b0000, 32'h0, 32'h0, 1};
    vecs[9]  = '{"size3_mis", 1,0,2'b11,0, 32'h70, 32'h0, 32'h0, 32'hFFFFFFFF,
                 32'h70, 4'b0000, 32'h0, 32'h0, 1};
    vecs[10] = '{"lw_negimm", 1,0,LSU_W,1, 32'h100, 32'hFFFFFFFC, 32'h0, 32'hCAFEF00D,
                 32'hFC, 4'b0000, 32'h0, 32'hCAFEF00D, 0};

    // Reset state
    tick(); tick();
    check("rst_o_valid", 64'(o_valid), 64'(0));
    check("rst_o_busy", 64'(o_busy), 64'(0));
    check("rst_o_ready", 64'(o_ready), 64'(1));
    check("rst_m_valid", 64'(dmem_m_valid), 64'(0));
    check("rst_misaligned", 64'(o_misaligned), 64'(0));
    check("rst_load_data", 64'(o_load_data), 64'(0));
    check("rst_fault_addr", 64'(o_fault_addr), 64'(0));
    check("rst_uop", 64'(o_lsu_uop), 64'(0));
    rst_n = 1'b1;
    tick();

    // Single-op vectors with memory always ready
    dmem_s_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      u         = mk_uop(vecs[i].is_load, vecs[i].is_store, vecs[i].size, vecs[i].sext, vecs[i].imm);
      rdata_drv = vecs[i].rdata;
      e.load    = vecs[i].exp_load;
      e.mis     = vecs[i].exp_mis;
      e.fault   = vecs[i].exp_mis ? vecs[i].exp_addr : 32'h0;
      e.uop     = u;
      issue(u, vecs[i].base, vecs[i].sdata, 1'b1, e);
      check({vecs[i].name, "_m_valid"}, 64'(dmem_m_valid), 64'(!vecs[i].exp_mis));
      if (!vecs[i].exp_mis) begin
        check({vecs[i].name, "_addr"}, 64'(dmem_m_addr), 64'(vecs[i].exp_addr));
        check({vecs[i].name, "_wstrb"}, 64'(dmem_m_wstrb), 64'(vecs[i].exp_strb));
        if (vecs[i].is_store)
          check({vecs[i].name, "_wdata"}, 64'(dmem_m_wdata), 64'(vecs[i].exp_wdata));
      end
      tick();
      check({vecs[i].name, "_latency"}, 64'(o_valid), 64'(1));
      tick();
      check({vecs[i].name, "_idle"}, 64'(o_busy), 64'(0));
    end

    // Five loads against a stalled memory, then drain in order
    dmem_s_ready = 1'b0;
    rdata_mode   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = 32'h4000 + 32'(4 * i);
      u = mk_uop(1'b1, 1'b0, LSU_W, 1'b0, 32'h0);
      e = '{load: mem_fn(a), mis: 1'b0, fault: 32'h0, uop: u};
      issue(u, a, 32'h0, 1'b1, e);
    end
    check("full_o_ready", 64'(o_ready), 64'(0));
    tick(); tick();
    check("stall_m_valid", 64'(dmem_m_valid), 64'(1));
    check("stall_addr_hold", 64'(dmem_m_addr), 64'(32'h4000));
    a = 32'h4010;
    u = mk_uop(1'b1, 1'b0, LSU_W, 1'b0, 32'h0);
    sb.push_back('{load: mem_fn(a), mis: 1'b0, fault: 32'h0, uop: u});
    i_valid = 1'b1; i_uop = u; i_addr_base = a; i_store_data = '0;
    tick();
    check("full_still_blocked", 64'(o_ready), 64'(0));
    dmem_s_ready = 1'b1;
    begin
      bit acc;
      acc = 1'b0;
      for (int c = 0; c < 20 && !acc; c++) begin
        acc = o_ready;
        tick();
      end
      i_valid = 1'b0;
      check("fifth_accepted", 64'(acc), 64'(1));
    end
    for (int c = 0; c < 40 && sb.size() != 0; c++) tick();
    check("drain_done", 64'(sb.size()), 64'(0));
    tick(); tick();
    check("drain_idle", 64'(o_busy), 64'(0));

    // Flush while the head store handshakes
    dmem_s_ready = 1'b0;
    e = '{load: 32'h0, mis: 1'b0, fault: 32'h0, uop: '0};
    issue(mk_uop(1'b0, 1'b1, LSU_W, 1'b0, 32'h0), 32'h80, 32'h11223344, 1'b0, e);
    issue(mk_uop(1'b1, 1'b0, LSU_W, 1'b0, 32'h0), 32'h84, 32'h0, 1'b0, e);
    issue(mk_uop(1'b1, 1'b0, LSU_W, 1'b0, 32'h0), 32'h88, 32'h0, 1'b0, e);
    memlog.delete();
    dmem_s_ready = 1'b1;
    i_flush      = 1'b1;
    i_valid      = 1'b1;
    i_uop        = mk_uop(1'b1, 1'b0, LSU_W, 1'b0, 32'h0);
    i_addr_base  = 32'h90;
    tick();
    i_flush = 1'b0;
    i_valid = 1'b0;
    check("flush_busy", 64'(o_busy), 64'(0));
    check("flush_no_valid", 64'(o_valid), 64'(0));
    tick();
    check("flush_no_valid_next", 64'(o_valid), 64'(0));
    check("flush_mem_count", 64'(memlog.size()), 64'(1));
    if (memlog.size() == 1) begin
      check("flush_mem_addr", 64'(memlog[0].addr), 64'(32'h80));
      check("flush_mem_wdata", 64'(memlog[0].wdata), 64'(32'h11223344));
      check("flush_mem_wstrb", 64'(memlog[0].wstrb), 64'(4'b1111));
    end

    // Reset with a full queue
    dmem_s_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      issue(mk_uop(1'b1, 1'b0, LSU_W, 1'b0, 32'h0), 32'h200 + 32'(4 * i), 32'h0, 1'b0, e);
    check("prerst_full", 64'(o_ready), 64'(0));
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_busy", 64'(o_busy), 64'(0));
    check("rst_mid_m_valid", 64'(dmem_m_valid), 64'(0));
    check("rst_mid_o_valid", 64'(o_valid), 64'(0));
    check("rst_mid_load_data", 64'(o_load_data), 64'(0));
    check("rst_mid_uop", 64'(o_lsu_uop), 64'(0));
    check("rst_mid_ready", 64'(o_ready), 64'(1));
    tick();
    rst_n        = 1'b1;
    dmem_s_ready = 1'b1;
    for (int c = 0; c < 8; c++) tick();
    check("postrst_busy", 64'(o_busy), 64'(0));
    check("sb_empty", 64'(sb.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
